// File: rtl/comb_sweep_checker_if.sv
// Connection bundle between the sweep checker, the circuit under test and the
// board-level start/status I/O.
interface comb_sweep_checker_if #(
   parameter int N_IN  = 2,
   parameter int OUT_W = 1,
   parameter int ERR_W = 8
);
   logic             start;
   logic [N_IN-1:0]  sweep_vec;
   logic             strobe;
   logic [OUT_W-1:0] dut_out;
   logic [OUT_W-1:0] exp_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [N_IN-1:0]  fail_vec;
   logic [1:0]       fail_phase;

   modport master (
      input  start, dut_out, exp_out,
      output sweep_vec, strobe, busy, done, pass, err_cnt, fail_vec, fail_phase
   );

   modport slave (
      output start, dut_out, exp_out,
      input  sweep_vec, strobe, busy, done, pass, err_cnt, fail_vec, fail_phase
   );
endinterface

// File: rtl/comb_sweep_checker.sv
// Exhaustive sweep exerciser: applies every input vector with a low/high/low
// strobe sequence and compares the DUT against a golden model at each phase end.
module comb_sweep_checker #(
   parameter int N_IN   = 2,
   parameter int OUT_W  = 1,
   parameter int SETTLE = 5,
   parameter int ERR_W  = 8
) (
   input logic clk,
   input logic rst,
   comb_sweep_checker_if.master bus
);
   localparam int CW = $clog2(SETTLE + 1);
   localparam logic [CW-1:0]    LAST_CNT = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0]  LAST_VEC = '1;
   localparam logic [ERR_W-1:0] MAX_ERR  = '1;
   localparam logic [1:0] PH_PRE  = 2'd0;
   localparam logic [1:0] PH_HIGH = 2'd1;
   localparam logic [1:0] PH_POST = 2'd2;
   localparam logic [1:0] PH_NONE = 2'd3;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_HIGH, S_POST, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic              strobe_q, strobe_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [N_IN-1:0]   fvec_q, fvec_d;
   logic [1:0]        fphase_q, fphase_d;
   logic              sample;
   logic [1:0]        phase_code;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         vec_q    <= '0;
         strobe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= '0;
         fvec_q   <= '0;
         fphase_q <= PH_NONE;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vec_q    <= vec_d;
         strobe_q <= strobe_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
         fvec_q   <= fvec_d;
         fphase_q <= fphase_d;
      end
   end

   // Strobe is registered alongside the phase change so it is high for exactly SETTLE cycles.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      vec_d      = vec_q;
      strobe_d   = strobe_q;
      busy_d     = busy_q;
      done_d     = done_q;
      err_d      = err_q;
      fvec_d     = fvec_q;
      fphase_d   = fphase_q;
      sample     = 1'b0;
      phase_code = PH_NONE;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d  = S_PRE;
               cnt_d    = '0;
               vec_d    = '0;
               strobe_d = 1'b0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               err_d    = '0;
               fvec_d   = '0;
               fphase_d = PH_NONE;
            end
         end
         S_PRE: begin
            phase_code = PH_PRE;
            if (cnt_q == LAST_CNT) begin
               sample   = 1'b1;
               state_d  = S_HIGH;
               cnt_d    = '0;
               strobe_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HIGH: begin
            phase_code = PH_HIGH;
            if (cnt_q == LAST_CNT) begin
               sample   = 1'b1;
               state_d  = S_POST;
               cnt_d    = '0;
               strobe_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_POST: begin
            phase_code = PH_POST;
            if (cnt_q == LAST_CNT) begin
               sample = 1'b1;
               cnt_d  = '0;
               if (vec_q == LAST_VEC) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_PRE;
                  vec_d   = vec_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Only the first failure is recorded; the counter saturates instead of wrapping.
      if (sample && (bus.dut_out != bus.exp_out)) begin
         if (err_q != MAX_ERR) begin
            err_d = err_q + 1'b1;
         end
         if (fphase_q == PH_NONE) begin
            fvec_d   = vec_q;
            fphase_d = phase_code;
         end
      end
   end

   assign bus.sweep_vec  = vec_q;
   assign bus.strobe     = strobe_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.pass       = done_q && (err_q == '0);
   assign bus.err_cnt    = err_q;
   assign bus.fail_vec   = fvec_q;
   assign bus.fail_phase = fphase_q;
endmodule

// File: tb/tb_comb_sweep_checker.sv
// Directed bench for comb_sweep_checker: three instances cover the default
// configuration, a narrow saturating counter and single-cycle phases.
module tb_comb_sweep_checker;
   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   logic inject_a;
   logic invert_c;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   comb_sweep_checker_if #(.N_IN(2), .OUT_W(1), .ERR_W(8)) bus_a ();
   comb_sweep_checker_if #(.N_IN(2), .OUT_W(1), .ERR_W(3)) bus_b ();
   comb_sweep_checker_if #(.N_IN(3), .OUT_W(2), .ERR_W(8)) bus_c ();

   comb_sweep_checker #(.N_IN(2), .OUT_W(1), .SETTLE(5), .ERR_W(8)) dut_a (
      .clk(clk), .rst(rst_a), .bus(bus_a));
   comb_sweep_checker #(.N_IN(2), .OUT_W(1), .SETTLE(5), .ERR_W(3)) dut_b (
      .clk(clk), .rst(rst_b), .bus(bus_b));
   comb_sweep_checker #(.N_IN(3), .OUT_W(2), .SETTLE(1), .ERR_W(8)) dut_c (
      .clk(clk), .rst(rst_c), .bus(bus_c));

   // Circuits under test and their golden models; faults are switched in by flags.
   assign bus_a.exp_out = ^{bus_a.sweep_vec, bus_a.strobe};
   assign bus_a.dut_out = (bus_a.sweep_vec[0] ^ bus_a.sweep_vec[1] ^ bus_a.strobe)
                          ^ (inject_a && (bus_a.sweep_vec == 2'd2) && bus_a.strobe);
   assign bus_b.exp_out = bus_b.sweep_vec[0] & bus_b.strobe;
   assign bus_b.dut_out = ~(bus_b.sweep_vec[0] & bus_b.strobe);
   assign bus_c.exp_out = {bus_c.sweep_vec[2] ^ bus_c.strobe, bus_c.sweep_vec[0] | bus_c.sweep_vec[1]};
   assign bus_c.dut_out = {bus_c.sweep_vec[2] ^ bus_c.strobe, bus_c.sweep_vec[1] | bus_c.sweep_vec[0]}
                          ^ {2{invert_c}};

   task automatic wait_done_a(output int cyc);
      cyc = 0;
      while (!bus_a.done && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic wait_done_b(output int cyc);
      cyc = 0;
      while (!bus_b.done && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic wait_done_c(output int cyc);
      cyc = 0;
      while (!bus_c.done && cyc < 200) begin
         @(posedge clk); #1; cyc++;
      end
   endtask

   task automatic test_reset();
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      bus_a.start = 1'b0; bus_b.start = 1'b0; bus_c.start = 1'b0;
      inject_a = 1'b0; invert_c = 1'b0;
      #2 rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      #1;
      n_cmp++; if (bus_a.sweep_vec !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_vec got %0d want 0", bus_a.sweep_vec); end
      n_cmp++; if (bus_a.strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_strobe got %b want 0", bus_a.strobe); end
      n_cmp++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_busy got %b want 0", bus_a.busy); end
      n_cmp++; if (bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_done got %b want 0", bus_a.done); end
      n_cmp++; if (bus_a.pass !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pass got %b want 0", bus_a.pass); end
      n_cmp++; if (bus_a.err_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_err got %0d want 0", bus_a.err_cnt); end
      n_cmp++; if (bus_a.fail_vec !== 2'd0) begin n_fail++; $display("[TB] FAIL rst_fvec got %0d want 0", bus_a.fail_vec); end
      n_cmp++; if (bus_a.fail_phase !== 2'd3) begin n_fail++; $display("[TB] FAIL rst_fphase got %0d want 3", bus_a.fail_phase); end
      n_cmp++; if (bus_c.fail_phase !== 2'd3) begin n_fail++; $display("[TB] FAIL rst_c_fphase got %0d want 3", bus_c.fail_phase); end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_busy got %b want 0", bus_a.busy); end
   endtask

   task automatic test_correct_sweep();
      logic exp_strobe;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         exp_strobe = ((k % 15) >= 5) && ((k % 15) < 10);
         n_cmp++; if (bus_a.sweep_vec !== 2'(k / 15)) begin n_fail++; $display("[TB] FAIL sweep_vec k=%0d got %0d want %0d", k, bus_a.sweep_vec, k / 15); end
         n_cmp++; if (bus_a.strobe !== exp_strobe) begin n_fail++; $display("[TB] FAIL strobe k=%0d got %b want %b", k, bus_a.strobe, exp_strobe); end
         n_cmp++; if (bus_a.busy !== 1'b1 || bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_done k=%0d got %b%b want 10", k, bus_a.busy, bus_a.done); end
         @(posedge clk); #1;
      end
      n_cmp++; if (bus_a.done !== 1'b1 || bus_a.busy !== 1'b0) begin n_fail++; $display("[TB] FAIL end_done_busy got %b%b want 10", bus_a.done, bus_a.busy); end
      n_cmp++; if (bus_a.err_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL ok_err got %0d want 0", bus_a.err_cnt); end
      n_cmp++; if (bus_a.pass !== 1'b1) begin n_fail++; $display("[TB] FAIL ok_pass got %b want 1", bus_a.pass); end
      n_cmp++; if (bus_a.fail_phase !== 2'd3) begin n_fail++; $display("[TB] FAIL ok_fphase got %0d want 3", bus_a.fail_phase); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus_a.done !== 1'b1 || bus_a.pass !== 1'b1) begin n_fail++; $display("[TB] FAIL hold_done_pass got %b%b want 11", bus_a.done, bus_a.pass); end
   endtask

   task automatic test_fault_injection();
      int cyc;
      inject_a = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      wait_done_a(cyc);
      n_cmp++; if (cyc !== 60) begin n_fail++; $display("[TB] FAIL fault_len got %0d want 60", cyc); end
      n_cmp++; if (bus_a.err_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL fault_err got %0d want 1", bus_a.err_cnt); end
      n_cmp++; if (bus_a.fail_vec !== 2'd2) begin n_fail++; $display("[TB] FAIL fault_fvec got %0d want 2", bus_a.fail_vec); end
      n_cmp++; if (bus_a.fail_phase !== 2'd1) begin n_fail++; $display("[TB] FAIL fault_fphase got %0d want 1", bus_a.fail_phase); end
      n_cmp++; if (bus_a.pass !== 1'b0) begin n_fail++; $display("[TB] FAIL fault_pass got %b want 0", bus_a.pass); end
      inject_a = 1'b0;
   endtask

   task automatic test_saturation();
      int cyc;
      int exp_err;
      @(posedge clk); #1 bus_b.start = 1'b1;
      @(posedge clk); #1 bus_b.start = 1'b0;
      for (int k = 0; k < 60; k++) begin
         exp_err = (k / 5 > 7) ? 7 : k / 5;
         n_cmp++; if (bus_b.err_cnt !== 3'(exp_err)) begin n_fail++; $display("[TB] FAIL sat_err k=%0d got %0d want %0d", k, bus_b.err_cnt, exp_err); end
         @(posedge clk); #1;
      end
      wait_done_b(cyc);
      n_cmp++; if (cyc !== 0) begin n_fail++; $display("[TB] FAIL sat_len extra cycles got %0d want 0", cyc); end
      n_cmp++; if (bus_b.err_cnt !== 3'd7) begin n_fail++; $display("[TB] FAIL sat_final got %0d want 7", bus_b.err_cnt); end
      n_cmp++; if (bus_b.fail_vec !== 2'd0) begin n_fail++; $display("[TB] FAIL sat_fvec got %0d want 0", bus_b.fail_vec); end
      n_cmp++; if (bus_b.fail_phase !== 2'd0) begin n_fail++; $display("[TB] FAIL sat_fphase got %0d want 0", bus_b.fail_phase); end
      n_cmp++; if (bus_b.pass !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_pass got %b want 0", bus_b.pass); end
   endtask

   task automatic test_reset_mid_sweep();
      int cyc;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      repeat (22) begin
         @(posedge clk); #1;
      end
      n_cmp++; if (bus_a.sweep_vec !== 2'd1 || bus_a.strobe !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_high got vec=%0d strobe=%b want vec=1 strobe=1", bus_a.sweep_vec, bus_a.strobe); end
      #2 rst_a = 1'b1;
      #1;
      n_cmp++; if (bus_a.sweep_vec !== 2'd0) begin n_fail++; $display("[TB] FAIL async_vec got %0d want 0", bus_a.sweep_vec); end
      n_cmp++; if (bus_a.strobe !== 1'b0) begin n_fail++; $display("[TB] FAIL async_strobe got %b want 0", bus_a.strobe); end
      n_cmp++; if (bus_a.busy !== 1'b0 || bus_a.done !== 1'b0) begin n_fail++; $display("[TB] FAIL async_busy_done got %b%b want 00", bus_a.busy, bus_a.done); end
      n_cmp++; if (bus_a.fail_phase !== 2'd3 || bus_a.err_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL async_results got fphase=%0d err=%0d want 3 0", bus_a.fail_phase, bus_a.err_cnt); end
      @(negedge clk) rst_a = 1'b0;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      n_cmp++; if (bus_a.sweep_vec !== 2'd0 || bus_a.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rerun_entry got vec=%0d busy=%b want 0 1", bus_a.sweep_vec, bus_a.busy); end
      wait_done_a(cyc);
      n_cmp++; if (cyc !== 60) begin n_fail++; $display("[TB] FAIL rerun_len got %0d want 60", cyc); end
      n_cmp++; if (bus_a.pass !== 1'b1) begin n_fail++; $display("[TB] FAIL rerun_pass got %b want 1", bus_a.pass); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      inject_a = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 55; k++) begin
         n_cmp++; if (bus_a.busy !== 1'b1 || bus_a.sweep_vec !== 2'(k / 15)) begin n_fail++; $display("[TB] FAIL held_start k=%0d got busy=%b vec=%0d want 1 %0d", k, bus_a.busy, bus_a.sweep_vec, k / 15); end
         @(posedge clk); #1;
      end
      bus_a.start = 1'b0;
      wait_done_a(cyc);
      n_cmp++; if (cyc !== 5) begin n_fail++; $display("[TB] FAIL held_len got %0d want 5", cyc); end
      n_cmp++; if (bus_a.err_cnt !== 8'd1) begin n_fail++; $display("[TB] FAIL first_err got %0d want 1", bus_a.err_cnt); end
      bus_a.start = 1'b1;
      @(posedge clk); #1 bus_a.start = 1'b0;
      n_cmp++; if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_flags got done=%b busy=%b want 0 1", bus_a.done, bus_a.busy); end
      n_cmp++; if (bus_a.err_cnt !== 8'd0 || bus_a.fail_phase !== 2'd3) begin n_fail++; $display("[TB] FAIL restart_clear got err=%0d fphase=%0d want 0 3", bus_a.err_cnt, bus_a.fail_phase); end
      n_cmp++; if (bus_a.sweep_vec !== 2'd0 || bus_a.fail_vec !== 2'd0) begin n_fail++; $display("[TB] FAIL restart_vec got vec=%0d fvec=%0d want 0 0", bus_a.sweep_vec, bus_a.fail_vec); end
      wait_done_a(cyc);
      n_cmp++; if (cyc !== 60) begin n_fail++; $display("[TB] FAIL restart_len got %0d want 60", cyc); end
      n_cmp++; if (bus_a.err_cnt !== 8'd1 || bus_a.fail_vec !== 2'd2 || bus_a.fail_phase !== 2'd1) begin n_fail++; $display("[TB] FAIL repeat_result got err=%0d fvec=%0d fphase=%0d want 1 2 1", bus_a.err_cnt, bus_a.fail_vec, bus_a.fail_phase); end
      inject_a = 1'b0;
   endtask

   task automatic test_settle_one();
      int   cyc;
      logic exp_strobe;
      invert_c = 1'b0;
      @(posedge clk); #1 bus_c.start = 1'b1;
      @(posedge clk); #1 bus_c.start = 1'b0;
      for (int k = 0; k < 24; k++) begin
         exp_strobe = ((k % 3) == 1);
         n_cmp++; if (bus_c.sweep_vec !== 3'(k / 3)) begin n_fail++; $display("[TB] FAIL s1_vec k=%0d got %0d want %0d", k, bus_c.sweep_vec, k / 3); end
         n_cmp++; if (bus_c.strobe !== exp_strobe) begin n_fail++; $display("[TB] FAIL s1_strobe k=%0d got %b want %b", k, bus_c.strobe, exp_strobe); end
         @(posedge clk); #1;
      end
      n_cmp++; if (bus_c.done !== 1'b1 || bus_c.pass !== 1'b1) begin n_fail++; $display("[TB] FAIL s1_done_pass got %b%b want 11", bus_c.done, bus_c.pass); end
      invert_c = 1'b1;
      @(posedge clk); #1 bus_c.start = 1'b1;
      @(posedge clk); #1 bus_c.start = 1'b0;
      wait_done_c(cyc);
      n_cmp++; if (cyc !== 24) begin n_fail++; $display("[TB] FAIL s1_len got %0d want 24", cyc); end
      n_cmp++; if (bus_c.err_cnt !== 8'd24) begin n_fail++; $display("[TB] FAIL s1_samples got %0d want 24", bus_c.err_cnt); end
      n_cmp++; if (bus_c.fail_vec !== 3'd0 || bus_c.fail_phase !== 2'd0) begin n_fail++; $display("[TB] FAIL s1_first got fvec=%0d fphase=%0d want 0 0", bus_c.fail_vec, bus_c.fail_phase); end
      invert_c = 1'b0;
   endtask

   initial begin
      test_reset();
      test_correct_sweep();
      test_fault_injection();
      test_saturation();
      test_reset_mid_sweep();
      test_back_to_back();
      test_settle_one();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired got running want finished");
      $fatal(1, "[TB] watchdog");
   end
endmodule

// File: doc/comb_sweep_checker.md
Name: comb_sweep_checker

Overview:
- Synthesizable, parametrised exhaustive-sweep exerciser for small combinational blocks under test.
- Drives every value of an N_IN-bit input vector. For each vector it runs a three-phase strobe sequence: strobe low, strobe high, strobe low.
- Samples the DUT output against a golden-model output at the end of every phase, counts mismatches and records the first failure.
- Sits between board-level start/status I/O and the circuit under test, replacing hand-written sweep benches with on-chip self-check.

Parameters:
- N_IN, 2, width of the swept input vector (1..8); vectors 0 .. 2^N_IN-1 are applied in ascending order.
- OUT_W, 1, width of the DUT output and golden output compared each sample (1..8).
- SETTLE, 5, clock cycles per phase (>=1).
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE or DONE to begin a sweep.
- sweep_vec  out  N_IN  current stimulus vector to the DUT.
- strobe  out  1  phase strobe to the DUT (the pulsed input).
- dut_out  in  OUT_W  output of the circuit under test.
- exp_out  in  OUT_W  golden-model output for the current sweep_vec/strobe.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next start or reset.
- pass  out  1  done && (err_cnt == 0).
- err_cnt  out  ERR_W  mismatch count, saturating at 2^ERR_W-1.
- fail_vec  out  N_IN  sweep_vec at the first mismatch.
- fail_phase  out  2  phase of the first mismatch: 0=PRE, 1=HIGH, 2=POST, 3=none.

Behaviour:
- Reset (asynchronous, any time, including mid-sweep):
  - state=IDLE; sweep_vec=0; strobe=0; busy=0; done=0; pass=0; err_cnt=0; fail_vec=0; fail_phase=3.
  - Internal phase counter and vector counter are cleared.
- States: IDLE, PRE, HIGH, POST, DONE. Outputs are registered.
- IDLE: start=1 -> PRE on the next edge.
  - On that edge: sweep_vec=0, phase counter=0, err_cnt=0, fail_phase=3, busy=1.
- PRE: strobe=0 for SETTLE cycles. On the last cycle (counter==SETTLE-1) sample, then -> HIGH.
- HIGH: strobe=1 for SETTLE cycles. On the last cycle sample, then -> POST.
- POST: strobe=0 for SETTLE cycles. On the last cycle sample, then:
  - If sweep_vec != 2^N_IN-1: sweep_vec+1 and -> PRE.
  - Otherwise -> DONE; busy=0, done=1.
- Strobe timing: strobe registers together with the state change, so it is high for exactly SETTLE cycles per vector.
- sweep_vec changes only on the POST->PRE edge. It is stable across all three phases of a vector.
- Sample rule: mismatch = (dut_out != exp_out) on a sample cycle only. Non-sample cycles are never compared, which gives the DUT SETTLE-1 cycles of settling.
- On a mismatch: err_cnt increments unless already all-ones (saturate, no wrap).
- First mismatch only (fail_phase==3): capture fail_vec=sweep_vec and fail_phase=current phase. Later mismatches do not overwrite.
- Sweep length: exactly 3*SETTLE*2^N_IN cycles from the first PRE cycle to the last POST cycle. done rises on the following edge.
- DONE:
  - Results hold; pass = (err_cnt==0).
  - start=1 -> restart exactly as from IDLE: counters/results cleared and done=0 on the same edge that enters PRE.
- start while busy is ignored. No abort input; use rst.
- SETTLE=1: each phase lasts one cycle and every cycle is a sample cycle.
- Counter widths: phase counter $clog2(SETTLE+1) bits. The vector counter must not overflow at N_IN=8 (terminal test uses equality to all-ones).

Test Plan:
- Correct DUT (N_IN=2, SETTLE=5, exp_out tied to the same function as dut_out), start pulse:
  - sweep_vec steps 0,1,2,3; strobe high cycles 5-9 of each 15-cycle vector.
  - done after 60 cycles; err_cnt=0; pass=1; fail_phase=3.
- Fault injection: dut_out forced wrong only when sweep_vec==2 && strobe==1:
  - err_cnt=1, fail_vec=2, fail_phase=1, pass=0.
- Stuck-inverted DUT (dut_out = ~exp_out always), ERR_W=3:
  - 12 samples occur; err_cnt saturates at 7.
  - fail_vec=0, fail_phase=0.
- rst asserted mid-HIGH of vector 1:
  - All outputs return to reset values immediately (asynchronous, before the next edge).
  - After rst release, a new start runs a full 60-cycle sweep from vector 0.
- start held high through the sweep, then re-pulsed in DONE:
  - No restart while busy.
  - Restart from DONE clears done/err_cnt on the entry edge and repeats an identical sweep.
- SETTLE=1, N_IN=3:
  - Sweep takes 24 cycles; strobe high exactly 1 cycle per vector; 24 samples compared.
